sdram_host_arbiter: RTL and testbench

Round-robin arbiter that shares the single host port of sdram_controller (haddr/data_input/data_output/rd_enable/wr_enable/busy) between NUM_PORTS requesters. Accepts one transaction at a time and holds the enable until the controller acknowledges with busy. It waits for busy to fall and then returns read data or write completion to the granted requester. Sits between the client blocks (e.g. frame fetch, CPU bridge) and sdram_controller.

---
 rtl/sdram_arb_pkg.sv | 24 ++
 rtl/sdram_rr_pick.sv | 30 +++
 rtl/sdram_host_arbiter.sv | 122 ++++++++++++
 tb/tb_sdram_host_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM host-port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;

    // ceil(log2(n)), never below 1 so single-value counters still get a bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first valid port at or after ptr, modulo NUM_PORTS.
module sdram_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [PTR_W-1:0]     ptr,
    output logic [PTR_W-1:0]     grant,
    output logic                 any_valid
);

    logic [PTR_W-1:0] idx;

    // Scan from the far end down so the candidate closest to ptr wins last.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_PORTS);
            if (valid[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Round-robin sharing of the single sdram_controller host port between NUM_PORTS
// requesters; one transaction in flight, with an issue timeout that aborts stalled requests.
module sdram_host_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ISSUE_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic                        rsp_err,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ADDR_W-1:0]           haddr,
    output logic [DATA_W-1:0]           data_input,
    output logic                        rd_enable,
    output logic                        wr_enable,
    input  logic                        busy,
    input  logic [DATA_W-1:0]           data_output,
    output logic                        timeout_err
);

    localparam int PTR_W = clog2(NUM_PORTS);
    localparam int TMO_W = clog2(ISSUE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ISSUE_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(ISSUE_TIMEOUT);
    localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(NUM_PORTS - 1);

    arb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] pick;
    logic             any_valid;
    logic             we_q;
    logic [TMO_W-1:0] tmo_cnt;

    sdram_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (pick),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            grant       <= '0;
            we_q        <= 1'b0;
            tmo_cnt     <= '0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
            rsp_data    <= '0;
            haddr       <= '0;
            data_input  <= '0;
            rd_enable   <= 1'b0;
            wr_enable   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    // A busy controller (init/refresh) blocks new grants.
                    if (!busy && any_valid) begin
                        grant            <= pick;
                        ptr              <= (pick == PTR_TOP) ? '0 : pick + 1'b1;
                        haddr            <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
                        data_input       <= req_wdata[int'(pick)*DATA_W +: DATA_W];
                        we_q             <= req_we[pick];
                        wr_enable        <= req_we[pick];
                        rd_enable        <= !req_we[pick];
                        req_ready[pick]  <= 1'b1;
                        tmo_cnt          <= '0;
                        state            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (busy) begin
                        rd_enable <= 1'b0;
                        wr_enable <= 1'b0;
                        state     <= ST_WAIT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rd_enable        <= 1'b0;
                        wr_enable        <= 1'b0;
                        timeout_err      <= 1'b1;
                        rsp_err          <= 1'b1;
                        rsp_valid[grant] <= 1'b1;
                        state            <= ST_RESP;
                    end else begin
                        tmo_cnt <= (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!busy) begin
                        if (!we_q) rsp_data <= data_output;
                        rsp_err          <= 1'b0;
                        rsp_valid[grant] <= 1'b1;
                        state            <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_err <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed bench with a small controller model and a response scoreboard.
module tb_sdram_host_arbiter;

    localparam int NP  = 3;
    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic             rsp_err, rd_enable, wr_enable, busy, timeout_err;
    logic [DW-1:0]    rsp_data, data_input, data_output;
    logic [AW-1:0]    haddr;

    logic          init_busy, ctl_busy, ctrl_en;
    logic [DW-1:0] rd_val, last_data;
    int            ctl_cnt;
    assign busy = init_busy | ctl_busy;

    typedef struct {
        int            port;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   tests = 0;
    int   fails = 0;

    sdram_host_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ISSUE_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .haddr(haddr), .data_input(data_input), .rd_enable(rd_enable), .wr_enable(wr_enable),
        .busy(busy), .data_output(data_output), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller: busy for 3 cycles after an enable; read data valid only as busy falls.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_busy    <= 1'b0;
            ctl_cnt     <= 0;
            data_output <= '0;
        end else if (ctl_cnt > 0) begin
            ctl_cnt <= ctl_cnt - 1;
            if (ctl_cnt == 1) begin
                ctl_busy    <= 1'b0;
                data_output <= rd_val;
            end
        end else if (ctrl_en && (rd_enable || wr_enable) && !ctl_busy) begin
            ctl_busy    <= 1'b1;
            ctl_cnt     <= 3;
            data_output <= 16'hdead;
        end
    end

    // Monitor: expectations are formed from the bench's own request state at accept time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req_ready != '0) begin
                    chk("ready_onehot", $countones(req_ready), 1);
                    for (int i = 0; i < NP; i++) begin
                        if (req_ready[i]) begin
                            grant_log.push_back(i);
                            e.port    = i;
                            e.err     = !ctrl_en;
                            e.data    = (!req_we[i] && ctrl_en) ? rd_val : last_data;
                            last_data = e.data;
                            sb.push_back(e);
                        end
                    end
                end
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_port", rsp_valid, 1 << e.port);
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_data", rsp_data, e.data);
                    end
                end
            end
        end
    end

    task automatic set_req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[p]              = we;
        req_addr[p*AW +: AW]   = a;
        req_wdata[p*DW +: DW]  = d;
        req_valid[p]           = 1'b1;
    endtask

    task automatic wait_ready(input int p);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!req_ready[p] && n < 300);
        chk($sformatf("ready_port%0d", p), req_ready[p], 1);
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk); #1;
    endtask

    task automatic run_alt(input int a, input int b, input string tag);
        int n;
        grant_log.delete();
        set_req(a, 1'b0, 24'h000100 + AW'(a), '0);
        set_req(b, 1'b1, 24'h000200 + AW'(b), 16'h1234);
        n = 0;
        while (grant_log.size() < 4 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        req_valid = '0;
        chk({tag, "_count"}, grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("%s_g%0d", tag, i), grant_log[i], (i % 2 == 0) ? a : b);
        drain();
    endtask

    initial begin
        int n;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        init_busy = 1'b1; ctrl_en = 1'b1; rd_val = '0; last_data = '0;

        #2 rst = 1'b1;
        #20;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rd_en", rd_enable, 0);
        chk("rst_wr_en", wr_enable, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_timeout_err", timeout_err, 0);

        // Held-off grant while the controller is busy, then write on port 0.
        set_req(0, 1'b1, 24'hfedbed, 16'd3333);
        @(negedge clk); rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("busy_no_grant", grant_log.size(), 0);
        init_busy = 1'b0;
        @(negedge clk); #1;
        chk("ready_after_busy", req_ready, 3'b001);
        chk("wr_haddr", haddr, 24'hfedbed);
        chk("wr_data_input", data_input, 16'd3333);
        chk("wr_en_on", wr_enable, 1);
        chk("wr_rd_en_off", rd_enable, 0);
        req_valid[0] = 1'b0;
        @(negedge clk); #1;
        chk("wr_held_busy", {busy, wr_enable}, 2'b11);
        @(negedge clk); #1;
        chk("wr_dropped", wr_enable, 0);
        drain();

        // Read on port 1.
        rd_val = 16'hbbbb;
        set_req(1, 1'b0, 24'hbedfed, 16'h0);
        wait_ready(1);
        chk("rd_en_on", rd_enable, 1);
        chk("rd_wr_en_off", wr_enable, 0);
        chk("rd_haddr", haddr, 24'hbedfed);
        drain();

        // Round robin: ports 0,1, then seed ptr to 0 via port 2 and run ports 0,2.
        rd_val = 16'h5a5a;
        run_alt(0, 1, "alt01");
        set_req(2, 1'b0, 24'h00abcd, 16'h0);
        wait_ready(2);
        drain();
        rd_val = 16'h7e7e;
        run_alt(0, 2, "alt02");

        // Controller never acknowledges.
        ctrl_en = 1'b0;
        set_req(0, 1'b0, 24'h123456, 16'h0);
        wait_ready(0);
        n = 0;
        while (rd_enable && n < 100) begin
            n++;
            @(negedge clk); #1;
        end
        chk("tmo_enable_cycles", n, TMO);
        drain();
        chk("tmo_sticky", timeout_err, 1);
        ctrl_en = 1'b1;
        set_req(1, 1'b1, 24'h654321, 16'hcafe);
        wait_ready(1);
        drain();
        chk("tmo_still_sticky", timeout_err, 1);

        // Reset while waiting on the controller: port 0 served last, so ptr would favour port 1.
        rd_val = 16'h4321;
        set_req(0, 1'b0, 24'h0f0f0f, 16'h0);
        wait_ready(0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("in_wait", {busy, rd_enable}, 2'b10);
        rst = 1'b1;
        #1;
        chk("arst_rd_en", rd_enable, 0);
        chk("arst_wr_en", wr_enable, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_haddr", haddr, 0);
        chk("arst_timeout_err", timeout_err, 0);
        sb.delete();
        last_data = '0;
        grant_log.delete();
        set_req(0, 1'b0, 24'h111111, 16'h0);
        set_req(1, 1'b0, 24'h222222, 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (grant_log.size() < 1 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        req_valid = '0;
        chk("post_rst_grant_cnt", grant_log.size(), 1);
        if (grant_log.size() > 0) chk("post_rst_port0_wins", grant_log[0], 0);
        drain();
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
